// File: rtl/imm_gen_stage.sv
// Registered immediate/target generator between decode and execute.
// A main register drives the outputs and a skid register absorbs one extra entry under back-pressure.
module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the in side and the out side are independent, and out_imm/out_err hold while stalled.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   main_imm_q;
  logic              main_err_q;
  logic [XLEN-1:0]   skid_imm_q;
  logic              skid_err_q;

  logic [XLEN-1:0]   pc4;
  logic [XLEN-1:0]   sext;
  logic [XLEN-1:0]   gen_imm_d;
  logic              gen_err_d;
  logic              acc_in;
  logic              acc_out;

  assign pc4  = in_pc + XLEN'(4);
  assign sext = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};

  // Any code above 6 (including out-of-range codes for wider MODE_W) is illegal.
  always_comb begin
    gen_imm_d = '0;
    gen_err_d = 1'b0;
    case (in_mode)
      MODE_W'(0): gen_imm_d = XLEN'(in_ir[15:0]);
      MODE_W'(1): gen_imm_d = sext;
      MODE_W'(2): gen_imm_d = XLEN'(in_ir[10:6]);
      MODE_W'(3): gen_imm_d = '0;
      MODE_W'(4): gen_imm_d = sext << 16;
      MODE_W'(5): gen_imm_d = pc4 + (sext << 2);
      MODE_W'(6): gen_imm_d = {pc4[XLEN-1:28], in_ir[25:0], 2'b00};
      default: begin
        gen_imm_d = '0;
        gen_err_d = 1'b1;
      end
    endcase
  end

  assign acc_in  = in_valid & in_ready_q;
  assign acc_out = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_imm_q  <= '0;
      main_err_q  <= 1'b0;
      skid_imm_q  <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (acc_in) begin
            main_imm_q  <= gen_imm_d;
            main_err_q  <= gen_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc_in && !acc_out) begin
            skid_imm_q <= gen_imm_d;
            skid_err_q <= gen_err_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (acc_in && acc_out) begin
            main_imm_q <= gen_imm_d;
            main_err_q <= gen_err_d;
            in_ready_q <= 1'b1;
          end else if (acc_out) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_EMPTY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (acc_out) begin
            main_imm_q <= skid_imm_q;
            main_err_q <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = main_imm_q;
  assign out_err   = main_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit and a 64-bit instance share one stimulus stream
// and are compared against a FIFO reference model built from the mode rules.
module tb_imm_gen_stage;

  localparam int W = 1 + 64 + 32;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ir;
  logic [63:0] pc64;
  logic [2:0]  in_mode;
  logic        out_ready;

  logic        rdy32, rdy64, v32, v64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [1:0]  st32, st64;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic started = 1'b0;
  logic after_rst = 1'b0;

  imm_gen_stage #(.XLEN(32), .MODE_W(3)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_ir(in_ir), .in_pc(pc64[31:0]), .in_mode(in_mode), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .out_err(err32), .dbg_state(st32)
  );

  imm_gen_stage #(.XLEN(64), .MODE_W(3)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_ir(in_ir), .in_pc(pc64), .in_mode(in_mode), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_err(err64), .dbg_state(st64)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: operand value computed with plain integer arithmetic, truncated to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] ir, input logic [63:0] pc,
                                          input int mode, input int xlen);
    logic [63:0] mask, s, p4;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    s    = 64'($signed(ir[15:0]));
    p4   = (pc + 64'd4) & mask;
    case (mode)
      0: return 64'(ir[15:0]);
      1: return s & mask;
      2: return 64'((ir / 64) % 32);
      4: return (s * 64'd65536) & mask;
      5: return (p4 + s * 64'd4) & mask;
      6: return (p4 & ~64'h0FFF_FFFF) | (64'(ir % (1 << 26)) * 64'd4);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_entry(input logic [31:0] ir, input logic [63:0] pc,
                                             input int mode);
    logic [63:0] r32, r64;
    r32 = ref_imm(ir, pc, mode, 32);
    r64 = ref_imm(ir, pc, mode, 64);
    return {(mode == 7), r64, r32[31:0]};
  endfunction

  // scoreboard: checks the outputs of the previous edge, then predicts the next edge
  always @(negedge clk) begin
    logic exp_rdy;
    logic [W-1:0] head;
    exp_rdy = !after_rst && (exp_q.size() < 2);
    if (started) begin
      check("out_valid32", 64'(v32), 64'(exp_q.size() > 0));
      check("out_valid64", 64'(v64), 64'(exp_q.size() > 0));
      check("in_ready32", 64'(rdy32), 64'(exp_rdy));
      check("in_ready64", 64'(rdy64), 64'(exp_rdy));
      if (after_rst) begin
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_err32", 64'(err32), 64'd0);
      end else if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("imm32", 64'(imm32), 64'(head[31:0]));
        check("imm64", imm64, head[95:32]);
        check("err32", 64'(err32), 64'(head[96]));
        check("err64", 64'(err64), 64'(head[96]));
      end
    end
    if (rst) begin
      exp_q.delete();
      after_rst = 1'b1;
      started   = 1'b1;
    end else begin
      if (started) begin
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (in_valid && exp_rdy) exp_q.push_back(ref_entry(in_ir, pc64, int'(in_mode)));
      end
      after_rst = 1'b0;
    end
  end

  // driver
  task automatic cycle(input logic v, input logic [31:0] ir, input logic [63:0] pc,
                       input logic [2:0] m, input logic ordy, input logic fl, input logic r);
    in_valid  = v;
    in_ir     = ir;
    pc64      = pc;
    in_mode   = m;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] golden[8];

  initial begin
    golden[0] = 32'h0000_8344; golden[1] = 32'hFFFF_8344;
    golden[2] = 32'h0000_000D; golden[3] = 32'h0000_0000;
    golden[4] = 32'h8344_0000; golden[5] = 32'h003E_0D24;
    golden[6] = 32'h0026_0D10; golden[7] = 32'h0000_0000;

    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);

    // mode sweep
    for (int m = 0; m < 8; m++) begin
      cycle(1, 32'h2409_8344, 64'h0040_0010, 3'(m), 1, 0, 0);
      check("sweep_imm", 64'(imm32), 64'(golden[m]));
      check("sweep_err", 64'(err32), 64'(m == 7));
    end
    cycle(0, 0, 0, 0, 1, 0, 0);

    // back-pressure: two accepted, third held until the skid drains
    cycle(1, 32'h0000_0001, 64'h100, 3'd1, 0, 0, 0);
    cycle(1, 32'h0000_0002, 64'h100, 3'd1, 0, 0, 0);
    check("bp_in_ready", 64'(rdy32), 64'd0);
    check("bp_head", 64'(imm32), 64'd1);
    cycle(1, 32'h0000_0003, 64'h100, 3'd1, 0, 0, 0);
    check("bp_hold", 64'(imm32), 64'd1);
    cycle(1, 32'h0000_0003, 64'h100, 3'd1, 1, 0, 0);
    check("bp_second", 64'(imm32), 64'd2);
    cycle(1, 32'h0000_0003, 64'h100, 3'd1, 1, 0, 0);
    check("bp_third", 64'(imm32), 64'd3);
    cycle(0, 0, 0, 0, 1, 0, 0);

    // wrap-around and wide sign/LUI
    cycle(1, 32'h0000_0004, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1, 0, 0);
    check("wrap32", 64'(imm32), 64'h0000_000C);
    check("wrap64", imm64, 64'h0000_000C);
    cycle(1, 32'h0000_8000, 64'h0, 3'd1, 1, 0, 0);
    check("sign64", imm64, 64'hFFFF_FFFF_FFFF_8000);
    cycle(1, 32'h0000_8000, 64'h0, 3'd4, 1, 0, 0);
    check("lui64", imm64, 64'hFFFF_FFFF_8000_0000);
    cycle(0, 0, 0, 0, 1, 0, 0);

    // flush in the two-entry state with an input offered
    cycle(1, 32'h0000_0011, 64'h0, 3'd0, 0, 0, 0);
    cycle(1, 32'h0000_0012, 64'h0, 3'd0, 0, 0, 0);
    check("two_state", 64'(st32), 64'd2);
    cycle(1, 32'h0000_0013, 64'h0, 3'd0, 0, 1, 0);
    check("flush_valid", 64'(v32), 64'd0);
    check("flush_ready", 64'(rdy32), 64'd1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("flush_empty", 64'(v32), 64'd0);

    // reset while one entry is held
    cycle(1, 32'h0000_0021, 64'h0, 3'd0, 0, 0, 0);
    cycle(1, 32'h0000_0022, 64'h0, 3'd0, 0, 0, 1);
    check("rst_valid", 64'(v32), 64'd0);
    check("rst_ready", 64'(rdy32), 64'd0);
    check("rst_imm", 64'(imm32), 64'd0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("rst_ready_rise", 64'(rdy32), 64'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, {$urandom, $urandom},
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 200) == 0));
    end
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
